decode_stage: RTL

Instruction-decode stage of the five-stage RISC-V pipeline, directly downstream of the fetch stage. It latches `PC_IF`/`INSTRUCTION_IF` in the IF/ID pipeline register and reads the 32×32 register file. It generates the sign-extended immediate and detects load-use hazards, driving `PC_write` back to fetch. It also applies flushes when a taken branch resolves.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/register_file.sv | 50 +++++
 rtl/decode_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the pipeline stages: data width, the canonical
// NOP encoding and the major opcodes that carry an immediate.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/register_file.sv
// 32 x 32 integer register file: two combinational read ports, one write port.
// x0 is hardwired to zero, and a write landing in the same cycle as a read of
// the same register is forwarded so ID sees the value being written back.
module register_file
   import riscv_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [4:0]      i_rs1_addr,
   input  logic [4:0]      i_rs2_addr,
   input  logic            i_we,
   input  logic [4:0]      i_rd_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data
);

   logic [XLEN-1:0] r_regs [32];
   logic            w_wr_en;

   assign w_wr_en = i_we && (i_rd_addr != 5'd0);

   // Write port; reset clears every entry so no stale data survives a restart.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[i_rd_addr] <= i_wdata;
      end
   end

   // Read ports: x0 reads zero, otherwise forward a same-cycle write-back.
   always_comb begin
      o_rs1_data = r_regs[i_rs1_addr];
      o_rs2_data = r_regs[i_rs2_addr];
      if (i_rs1_addr == 5'd0) begin
         o_rs1_data = '0;
      end else if (w_wr_en && (i_rd_addr == i_rs1_addr)) begin
         o_rs1_data = i_wdata;
      end
      if (i_rs2_addr == 5'd0) begin
         o_rs2_data = '0;
      end else if (w_wr_en && (i_rd_addr == i_rs2_addr)) begin
         o_rs2_data = i_wdata;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: IF/ID pipeline register, register-file
// read, immediate generation and load-use hazard detection. A taken branch
// (PCSrc) squashes IF/ID to a NOP and overrides any stall so fetch can load
// the branch target.
module decode_stage
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC_IF,
   input  logic [31:0] INSTRUCTION_IF,
   input  logic        PCSrc,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_rd,
   input  logic        RegWrite_WB,
   input  logic [4:0]  rd_WB,
   input  logic [31:0] write_data_WB,
   output logic        PC_write,
   output logic        IF_ID_write,
   output logic        bubble_ID,
   output logic [31:0] PC_ID,
   output logic [31:0] INSTRUCTION_ID,
   output logic [31:0] RS1_DATA,
   output logic [31:0] RS2_DATA,
   output logic [31:0] IMM_ID,
   output logic [4:0]  RS1_ID,
   output logic [4:0]  RS2_ID,
   output logic [4:0]  RD_ID,
   output logic [2:0]  FUNCT3_ID,
   output logic [6:0]  FUNCT7_ID,
   output logic [6:0]  OPCODE_ID
);

   logic [XLEN-1:0] r_pc_id;
   logic [31:0]     r_instr_id;
   logic            w_hazard;

   // IF/ID register: reset and flush both insert a NOP, a stall holds.
   always_ff @(posedge clk) begin
      if (reset || PCSrc) begin
         r_pc_id    <= '0;
         r_instr_id <= NOP_INSTR;
      end else if (IF_ID_write) begin
         r_pc_id    <= PC_IF;
         r_instr_id <= INSTRUCTION_IF;
      end
   end

   assign PC_ID          = r_pc_id;
   assign INSTRUCTION_ID = r_instr_id;
   assign OPCODE_ID      = r_instr_id[6:0];
   assign RD_ID          = r_instr_id[11:7];
   assign FUNCT3_ID      = r_instr_id[14:12];
   assign RS1_ID         = r_instr_id[19:15];
   assign RS2_ID         = r_instr_id[24:20];
   assign FUNCT7_ID      = r_instr_id[31:25];

   register_file u_regfile (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_rs1_addr (RS1_ID),
      .i_rs2_addr (RS2_ID),
      .i_we       (RegWrite_WB),
      .i_rd_addr  (rd_WB),
      .i_wdata    (write_data_WB),
      .o_rs1_data (RS1_DATA),
      .o_rs2_data (RS2_DATA)
   );

   // Load-use hazard: the load in EX targets a source of the instruction in ID.
   always_comb begin
      w_hazard    = ID_EX_MemRead && (ID_EX_rd != 5'd0) &&
                    ((ID_EX_rd == RS1_ID) || (ID_EX_rd == RS2_ID));
      PC_write    = !w_hazard || PCSrc;
      IF_ID_write = !w_hazard;
      bubble_ID   = w_hazard || PCSrc;
   end

   // Sign-extended immediate selected by the instruction format.
   always_comb begin
      IMM_ID = '0;
      case (OPCODE_ID)
         OP_LOAD, OP_IMM, OP_JALR:
            IMM_ID = {{20{r_instr_id[31]}}, r_instr_id[31:20]};
         OP_STORE:
            IMM_ID = {{20{r_instr_id[31]}}, r_instr_id[31:25], r_instr_id[11:7]};
         OP_BRANCH:
            IMM_ID = {{19{r_instr_id[31]}}, r_instr_id[31], r_instr_id[7],
                      r_instr_id[30:25], r_instr_id[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            IMM_ID = {r_instr_id[31:12], 12'b0};
         OP_JAL:
            IMM_ID = {{11{r_instr_id[31]}}, r_instr_id[31], r_instr_id[19:12],
                      r_instr_id[20], r_instr_id[30:21], 1'b0};
         default:
            IMM_ID = '0;
      endcase
   end

endmodule
